// File: rtl/pipeline_ctrl_unit.sv
// Per-stage valid/enable sequencer with load-use and memory-wait stalls, decode squash and run FSM.
// Outputs registered except stageEn/pcWrite; optional stall counter built only with PIPE_PERF_CNT_EN.
module pipeline_ctrl_unit #(
    parameter int NUM_STAGES   = 5,
    parameter int DECODE_STAGE = 1,
    parameter int MEM_STAGE    = 3,
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  startProcess,
    input  logic                  loadUseHazard,
    input  logic                  redirectID,
    input  logic                  endReqID,
    input  logic                  memReqMem,
    input  logic                  memReadyMem,
    output logic [NUM_STAGES-1:0] stageEn,
    output logic [NUM_STAGES-1:0] stageValid,
    output logic                  pcWrite,
    output logic [CNT_W-1:0]      retireCount,
    output logic [CNT_W-1:0]      stallCycles,
    output logic                  endProcess,
    output logic                  memTimeout,
    output logic [2:0]            state
);

    localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_STAGES-1:0] stage_valid_q, stage_valid_d;
    logic [CNT_W-1:0]      retire_q, retire_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  end_process_q, end_process_d;
    logic                  mem_timeout_q, mem_timeout_d;

    logic                  active;
    logic                  mem_stall;
    logic                  lu_stall;
    logic                  frozen;
    int                    freeze_idx;
    logic                  end_go;
    logic                  squash;
    logic                  timeout;
    logic                  fetch;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] shifted_valid;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]      stall_q, stall_d;
`endif

    always_comb begin
        active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        mem_stall  = active && stage_valid_q[MEM_STAGE] && memReqMem && !memReadyMem;
        lu_stall   = active && !mem_stall && loadUseHazard && stage_valid_q[DECODE_STAGE];
        frozen     = mem_stall || lu_stall;
        freeze_idx = mem_stall ? MEM_STAGE : (lu_stall ? DECODE_STAGE : -1);
        timeout    = mem_stall && (wait_cnt_q == WAIT_W'(MAX_MEM_WAIT - 1));
        end_go     = (state_q == ST_RUN) && endReqID && stage_valid_q[DECODE_STAGE] && !frozen;
        squash     = active && !frozen && stage_valid_q[DECODE_STAGE] && (redirectID || end_go);
        fetch      = (state_q == ST_RUN) && !end_go;
    end

    // Stages at or below the freeze point hold, the one above gets a bubble, the rest advance.
    always_comb begin
        stage_en      = '0;
        shifted_valid = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (s >= 1) begin
                stage_en[s] = active && (s > freeze_idx);
            end
            if (s <= freeze_idx) begin
                shifted_valid[s] = stage_valid_q[s];
            end else if (s == freeze_idx + 1) begin
                shifted_valid[s] = (s == 0) ? fetch : 1'b0;
            end else begin
                shifted_valid[s] = stage_valid_q[s-1];
            end
        end
        if (squash) begin
            for (int s = 1; s <= DECODE_STAGE; s++) begin
                shifted_valid[s] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        stage_valid_d = stage_valid_q;
        retire_d      = retire_q;
        wait_cnt_d    = '0;
        end_process_d = end_process_q;
        mem_timeout_d = mem_timeout_q;
`ifdef PIPE_PERF_CNT_EN
        stall_d       = stall_q;
        if (active && frozen && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (startProcess) begin
                    state_d       = ST_RUN;
                    stage_valid_d = '0;
                    retire_d      = '0;
                    end_process_d = 1'b0;
                    mem_timeout_d = 1'b0;
`ifdef PIPE_PERF_CNT_EN
                    stall_d       = '0;
`endif
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (stage_valid_q[NUM_STAGES-1] && (retire_q != {CNT_W{1'b1}})) begin
                    retire_d = retire_q + 1'b1;
                end
                if (mem_stall) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
                if (timeout) begin
                    // Valid bits are left untouched so the stuck state stays observable.
                    state_d       = ST_ERROR;
                    mem_timeout_d = 1'b1;
                end else begin
                    stage_valid_d = shifted_valid;
                    if ((state_q == ST_DRAIN) && !(|stage_valid_q)) begin
                        state_d       = ST_DONE;
                        end_process_d = 1'b1;
                    end else if (end_go) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= ST_IDLE;
            stage_valid_q <= '0;
            retire_q      <= '0;
            wait_cnt_q    <= '0;
            end_process_q <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_valid_q <= stage_valid_d;
            retire_q      <= retire_d;
            wait_cnt_q    <= wait_cnt_d;
            end_process_q <= end_process_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
    assign stallCycles = stall_q;
`else
    assign stallCycles = '0;
`endif

    assign stageEn     = stage_en;
    assign stageValid  = stage_valid_q;
    assign pcWrite     = (state_q == ST_RUN) && !frozen;
    assign retireCount = retire_q;
    assign endProcess  = end_process_q;
    assign memTimeout  = mem_timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Bench for pipeline_ctrl_unit: instruction-tag pipeline model, per-cycle compare, directed literals, random phase.
module tb_pipeline_ctrl_unit;

    localparam int N    = 5;
    localparam int DEC  = 1;
    localparam int MEM  = 3;
    localparam int MAXW = 15;
    localparam int CW   = 32;
    localparam longint CNT_MAX = (longint'(1) << CW) - 1;

    logic          clk;
    logic          rstN;
    logic          startProcess, loadUseHazard, redirectID, endReqID, memReqMem, memReadyMem;
    logic [N-1:0]  stageEn, stageValid;
    logic          pcWrite, endProcess, memTimeout;
    logic [CW-1:0] retireCount, stallCycles;
    logic [2:0]    state;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    pipeline_ctrl_unit #(
        .NUM_STAGES(N), .DECODE_STAGE(DEC), .MEM_STAGE(MEM), .MAX_MEM_WAIT(MAXW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstN(rstN), .startProcess(startProcess), .loadUseHazard(loadUseHazard),
        .redirectID(redirectID), .endReqID(endReqID), .memReqMem(memReqMem), .memReadyMem(memReadyMem),
        .stageEn(stageEn), .stageValid(stageValid), .pcWrite(pcWrite), .retireCount(retireCount),
        .stallCycles(stallCycles), .endProcess(endProcess), .memTimeout(memTimeout), .state(state)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each stage holds an instruction tag (0 = empty); instructions move, stall, vanish or retire.
    int     m_st;
    int     m_pipe[N];
    int     m_tag;
    longint m_ret, m_stl;
    int     m_wait;
    bit     m_end, m_tmo;

    function automatic int frz_of();
        bit act;
        act = (m_st == 1) || (m_st == 2);
        if (act && m_pipe[MEM] != 0 && memReqMem && !memReadyMem) return MEM;
        if (act && m_pipe[DEC] != 0 && loadUseHazard) return DEC;
        return -1;
    endfunction

    task automatic model_clear();
        foreach (m_pipe[i]) m_pipe[i] = 0;
        m_ret = 0; m_stl = 0; m_wait = 0; m_end = 0; m_tmo = 0;
    endtask

    task automatic model_step();
        int f;
        bit empty, ending, squash;
        f = frz_of();
        if (m_st == 1 || m_st == 2) begin
            if (m_pipe[N-1] != 0 && m_ret < CNT_MAX) m_ret++;
            if (f >= 0 && m_stl < CNT_MAX) m_stl++;
            if (f == MEM && m_wait == MAXW - 1) begin
                m_st = 4; m_tmo = 1; m_wait = 0;
            end else begin
                m_wait = (f == MEM) ? m_wait + 1 : 0;
                empty = 1;
                foreach (m_pipe[i]) if (m_pipe[i] != 0) empty = 0;
                ending = (m_st == 1) && endReqID && m_pipe[DEC] != 0 && f < 0;
                squash = f < 0 && m_pipe[DEC] != 0 && (redirectID || ending);
                for (int s = N - 1; s > f + 1; s--) m_pipe[s] = m_pipe[s-1];
                if (f >= 0) m_pipe[f+1] = 0;
                else begin
                    m_tag++;
                    m_pipe[0] = (m_st == 1 && !ending) ? m_tag : 0;
                end
                if (squash) for (int s = 1; s <= DEC; s++) m_pipe[s] = 0;
                if (m_st == 2 && empty) begin m_st = 3; m_end = 1; end
                else if (ending) m_st = 2;
            end
        end else if (startProcess) begin
            m_st = 1;
            model_clear();
        end
    endtask

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_st = 0;
            model_clear();
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin : compare
        int f;
        bit act;
        logic [N-1:0] en_e, v_e;
        longint stl_e;
        if (cmp_en) begin
            f = frz_of();
            act = (m_st == 1) || (m_st == 2);
            en_e = '0;
            v_e  = '0;
            for (int s = 0; s < N; s++) begin
                if (s >= 1) en_e[s] = act && (s > f);
                v_e[s] = (m_pipe[s] != 0);
            end
`ifdef PIPE_PERF_CNT_EN
            stl_e = m_stl;
`else
            stl_e = 0;
`endif
            check("state", longint'(state), longint'(m_st));
            check("stageValid", longint'(stageValid), longint'(v_e));
            check("stageEn", longint'(stageEn), longint'(en_e));
            check("pcWrite", longint'(pcWrite), longint'((m_st == 1) && (f < 0)));
            check("retireCount", longint'(retireCount), m_ret);
            check("stallCycles", longint'(stallCycles), stl_e);
            check("endProcess", longint'(endProcess), longint'(m_end));
            check("memTimeout", longint'(memTimeout), longint'(m_tmo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int hang;

    initial begin
        startProcess = 0; loadUseHazard = 0; redirectID = 0; endReqID = 0;
        memReqMem = 0; memReadyMem = 1;
        rstN = 1;
        #1 rstN = 0;
        tick(); tick();
        cmp_en = 1;
        check("rst_state", longint'(state), 0);
        check("rst_valid", longint'(stageValid), 0);
        check("rst_retire", longint'(retireCount), 0);
        check("rst_stageEn", longint'(stageEn), 0);
        check("rst_pcWrite", longint'(pcWrite), 0);
        check("rst_flags", longint'({endProcess, memTimeout}), 0);
        rstN = 1;
        tick();

        // Fill: start clears, then one stage per cycle.
        startProcess = 1; tick(); startProcess = 0;
        check("start_state", longint'(state), 1);
        check("start_valid", longint'(stageValid), 0);
        repeat (5) tick();
        check("fill_valid", longint'(stageValid), 5'b11111);
        check("fill_pcWrite", longint'(pcWrite), 1);
        repeat (5) tick();
        check("fill_retire", longint'(retireCount), 5);

        // Load-use bubble.
        loadUseHazard = 1; #1;
        check("lu_stageEn", longint'(stageEn), 5'b11100);
        check("lu_pcWrite", longint'(pcWrite), 0);
        tick(); loadUseHazard = 0;
        check("lu_bubble", longint'(stageValid), 5'b11011);
        #1 check("lu_resume_en", longint'(stageEn), 5'b11110);
        repeat (3) tick();
        check("refill_valid", longint'(stageValid), 5'b11111);

        // Memory stall three cycles.
        memReqMem = 1; memReadyMem = 0;
        repeat (3) begin
            #1;
            check("mem_stageEn", longint'(stageEn), 5'b10000);
            check("mem_pcWrite", longint'(pcWrite), 0);
            tick();
        end
        memReqMem = 0; memReadyMem = 1;
        check("mem_valid", longint'(stageValid), 5'b01111);

        // Redirect with load-use: stall wins, then redirect squashes.
        redirectID = 1; loadUseHazard = 1; #1;
        check("rdlu_pcWrite", longint'(pcWrite), 0);
        check("rdlu_stageEn", longint'(stageEn), 5'b11100);
        tick(); loadUseHazard = 0;
        check("rdlu_valid", longint'(stageValid), 5'b11011);
        #1 check("rd_stageEn", longint'(stageEn), 5'b11110);
        tick(); redirectID = 0;
        check("rd_squash", longint'(stageValid), 5'b10101);

        // Terminator and drain.
        tick();
        endReqID = 1; tick(); endReqID = 0;
        check("drain_state", longint'(state), 2);
        check("drain_pcWrite", longint'(pcWrite), 0);
        check("drain_valid", longint'(stageValid), 5'b10100);
        for (int i = 0; i < 12 && state != 3; i++) tick();
        check("done_state", longint'(state), 3);
        check("done_endProcess", longint'(endProcess), 1);
        startProcess = 1; tick(); startProcess = 0;
        check("restart_state", longint'(state), 1);
        check("restart_endProcess", longint'(endProcess), 0);
        check("restart_retire", longint'(retireCount), 0);

        // Memory timeout.
        repeat (4) tick();
        memReqMem = 1; memReadyMem = 0;
        repeat (14) tick();
        check("pre_timeout_state", longint'(state), 1);
        tick();
        check("timeout_state", longint'(state), 4);
        check("timeout_flag", longint'(memTimeout), 1);
        check("timeout_stageEn", longint'(stageEn), 0);
        memReqMem = 0; memReadyMem = 1;
        rstN = 0; #1;
        check("rst_after_err", longint'(state), 0);
        check("rst_after_err_valid", longint'(stageValid), 0);
        tick(); rstN = 1; tick();

        // Random phase.
        hang = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_st == 1 || m_st == 2) startProcess = ($urandom_range(0, 39) == 0);
            else startProcess = ($urandom_range(0, 3) == 0);
            loadUseHazard = ($urandom_range(0, 4) == 0);
            redirectID    = ($urandom_range(0, 5) == 0);
            endReqID      = ($urandom_range(0, 59) == 0);
            memReqMem     = ($urandom_range(0, 1) == 0);
            if (hang == 0 && $urandom_range(0, 199) == 0) hang = $urandom_range(5, 20);
            if (hang > 0) begin
                memReqMem = 1; memReadyMem = 0; hang--;
            end else begin
                memReadyMem = ($urandom_range(0, 3) != 0);
            end
            rstN = ($urandom_range(0, 799) != 0);
            tick();
        end
        rstN = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
